// File: rtl/enclave_load_ctrl_if.sv
// Read/write request-acknowledge ports between enclave_load_ctrl and the enclave memory fabric.
interface enclave_load_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_valid, rd_data, wr_ack
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_valid, rd_data, wr_ack
    );
endinterface

// File: rtl/enclave_load_ctrl.sv
// Copies an enclave image word by word and signals strt_cpy/done_cpy to the security monitor.
// Optional image checksum is enabled by defining ENCLAVE_LOAD_CHECKSUM_EN.
module enclave_load_ctrl #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                aclk,
    input  logic                nreset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_base,
    input  logic [ADDR_W-1:0]   dst_base,
    input  logic [LEN_W-1:0]    len_words,
    input  logic [DATA_W-1:0]   csum_exp,
    output logic                busy,
    output logic                err,
    output logic                strt_cpy,
    output logic                done_cpy,
    enclave_load_ctrl_if.master mem
);
    localparam int unsigned       WdogW    = $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_W-1:0] Stride   = ADDR_W'(DATA_W / 8);
    localparam logic [WdogW-1:0]  WdogLast = WdogW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StRd, StWr, StCheck, StDone, StErr} state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  idx_q, idx_d, len_q, len_d, idx_inc;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, idx_off;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [WdogW-1:0]  wdog_q, wdog_d;
    logic              accept, wdog_exp, last_word, csum_ok;

    assign accept    = start && (state_q == StIdle || state_q == StDone || state_q == StErr);
    assign idx_inc   = idx_q + LEN_W'(1);
    assign last_word = (idx_inc == len_q);
    assign wdog_exp  = (wdog_q == WdogLast);
    assign idx_off   = ADDR_W'(idx_q) * Stride;

`ifdef ENCLAVE_LOAD_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d, csum_exp_q, csum_exp_d;

    assign csum_ok = (csum_q == csum_exp_q);

    always_comb begin
        csum_d     = csum_q;
        csum_exp_d = csum_exp_q;
        if (accept) begin
            csum_d     = '0;
            csum_exp_d = csum_exp;
        end else if (state_q == StWr && mem.wr_ack) begin
            csum_d = csum_q + wdata_q;
        end
    end

    always_ff @(posedge aclk) begin
        if (!nreset) begin
            csum_q     <= '0;
            csum_exp_q <= '0;
        end else begin
            csum_q     <= csum_d;
            csum_exp_q <= csum_exp_d;
        end
    end
`else
    logic unused_csum_exp;
    assign unused_csum_exp = ^csum_exp;
    assign csum_ok         = 1'b1;
`endif

    always_ff @(posedge aclk) begin
        if (!nreset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            len_q   <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            wdata_q <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            wdata_q <= wdata_d;
            wdog_q  <= wdog_d;
        end
    end

    // A response in the expiry cycle takes priority over the watchdog.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) state_d = (len_words == '0) ? StCheck : StRd;
            end
            StRd: begin
                if (mem.rd_valid)  state_d = StWr;
                else if (wdog_exp) state_d = StErr;
            end
            StWr: begin
                if (mem.wr_ack)    state_d = last_word ? StCheck : StRd;
                else if (wdog_exp) state_d = StErr;
            end
            StCheck: state_d = csum_ok ? StDone : StErr;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        idx_d   = idx_q;
        len_d   = len_q;
        src_d   = src_q;
        dst_d   = dst_q;
        wdata_d = wdata_q;
        wdog_d  = wdog_q;
        if (accept) begin
            idx_d = '0;
            len_d = len_words;
            src_d = src_base;
            dst_d = dst_base;
        end
        if (state_q == StRd && mem.rd_valid) wdata_d = mem.rd_data;
        if (state_q == StWr && mem.wr_ack)   idx_d   = idx_inc;
        // Every entry into RD or WR is a state change, so one compare covers both restarts.
        if (state_d != state_q)                        wdog_d = '0;
        else if (state_q == StRd || state_q == StWr)   wdog_d = wdog_q + WdogW'(1);
    end

    always_comb begin
        busy        = 1'b0;
        strt_cpy    = 1'b0;
        done_cpy    = 1'b0;
        err         = 1'b0;
        mem.rd_req  = 1'b0;
        mem.rd_addr = '0;
        mem.wr_req  = 1'b0;
        mem.wr_addr = '0;
        mem.wr_data = wdata_q;
        unique case (state_q)
            StRd: begin
                busy        = 1'b1;
                strt_cpy    = 1'b1;
                mem.rd_req  = 1'b1;
                mem.rd_addr = src_q + idx_off;
            end
            StWr: begin
                busy        = 1'b1;
                strt_cpy    = 1'b1;
                mem.wr_req  = 1'b1;
                mem.wr_addr = dst_q + idx_off;
            end
            StCheck: begin
                busy     = 1'b1;
                strt_cpy = 1'b1;
            end
            StDone:  done_cpy = 1'b1;
            StErr:   err      = 1'b1;
            default: ;
        endcase
    end
endmodule
